// File: rtl/ili9341_frame_sequencer.sv
// Feeds the 9-bit SPI master: power-on wait, init table with timed delays, then endless CASET/PASET/RAMWR + RGB565 frames.
// One word in flight at a time; spi_valid only when spi_idle, pixel source stalls the stream via px_valid.
module ili9341_frame_sequencer #(
    parameter int WIDTH        = 240,
    parameter int HEIGHT       = 320,
    parameter int DELAY_CYCLES = 3000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_idle,
    output logic [8:0]  spi_data,
    output logic        spi_valid,
    input  logic [15:0] px_data,
    input  logic        px_valid,
    output logic        px_ready,
    output logic [7:0]  px_x,
    output logic [8:0]  px_y,
    output logic        init_done,
    output logic        frame_start
);
    typedef enum logic [3:0] {
        POWER_WAIT, INIT_FETCH, DELAY, SEND, WAIT_BUSY,
        WAIT_DONE, HDR_FETCH, PX_WAIT, PX_HI, PX_LO
    } state_t;
    typedef enum logic [1:0] {PH_INIT, PH_HDR, PH_HI, PH_LO} phase_t;

    localparam logic [15:0] COL_END   = 16'(WIDTH - 1);
    localparam logic [15:0] ROW_END   = 16'(HEIGHT - 1);
    localparam logic [7:0]  X_LAST    = 8'(WIDTH - 1);
    localparam logic [8:0]  Y_LAST    = 9'(HEIGHT - 1);
    localparam logic [31:0] DLY       = 32'(DELAY_CYCLES);
    localparam logic [3:0]  INIT_END  = 4'd9;
    localparam logic [3:0]  HDR_END   = 4'd11;

    state_t      state, state_nx;
    phase_t      phase;
    logic [31:0] cnt;
    logic [3:0]  init_idx, hdr_idx;
    logic [15:0] pix;
    logic        init_done_q;
    logic [9:0]  init_entry;
    logic [8:0]  hdr_word;
    logic        last_px;

    // bit9 marks a delay slot rather than a word to send
    always_comb begin
        init_entry = 10'h029;
        case (init_idx)
            4'd0: init_entry = 10'h001;
            4'd1: init_entry = 10'h200;
            4'd2: init_entry = 10'h011;
            4'd3: init_entry = 10'h200;
            4'd4: init_entry = 10'h03A;
            4'd5: init_entry = 10'h155;
            4'd6: init_entry = 10'h036;
            4'd7: init_entry = 10'h148;
            default: init_entry = 10'h029;
        endcase
    end

    always_comb begin
        hdr_word = 9'h02C;
        case (hdr_idx)
            4'd0:       hdr_word = 9'h02A;
            4'd1, 4'd2: hdr_word = 9'h100;
            4'd3:       hdr_word = {1'b1, COL_END[15:8]};
            4'd4:       hdr_word = {1'b1, COL_END[7:0]};
            4'd5:       hdr_word = 9'h02B;
            4'd6, 4'd7: hdr_word = 9'h100;
            4'd8:       hdr_word = {1'b1, ROW_END[15:8]};
            4'd9:       hdr_word = {1'b1, ROW_END[7:0]};
            default:    hdr_word = 9'h02C;
        endcase
    end

    assign last_px = (px_x == X_LAST) && (px_y == Y_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= POWER_WAIT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            POWER_WAIT: if (cnt >= DLY - 32'd1) state_nx = INIT_FETCH;
            INIT_FETCH: state_nx = init_entry[9] ? DELAY : SEND;
            DELAY:      if (cnt <= 32'd1) state_nx = INIT_FETCH;
            SEND:       if (spi_idle) state_nx = WAIT_BUSY;
            WAIT_BUSY:  if (!spi_idle) state_nx = WAIT_DONE;
            WAIT_DONE: begin
                if (spi_idle) begin
                    case (phase)
                        PH_INIT: state_nx = (init_idx == INIT_END) ? HDR_FETCH : INIT_FETCH;
                        PH_HDR:  state_nx = (hdr_idx == HDR_END) ? PX_WAIT : HDR_FETCH;
                        PH_HI:   state_nx = PX_LO;
                        default: state_nx = last_px ? HDR_FETCH : PX_WAIT;
                    endcase
                end
            end
            HDR_FETCH:  state_nx = SEND;
            PX_WAIT:    if (px_valid) state_nx = PX_HI;
            PX_HI:      state_nx = SEND;
            PX_LO:      state_nx = SEND;
            default:    state_nx = POWER_WAIT;
        endcase
    end

    always_comb begin
        spi_valid   = (state == SEND) && spi_idle;
        px_ready    = (state == PX_WAIT) && px_valid;
        frame_start = spi_valid && (phase == PH_HDR) && (hdr_idx == 4'd1);
        init_done   = init_done_q | frame_start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            init_idx    <= '0;
            hdr_idx     <= '0;
            phase       <= PH_INIT;
            spi_data    <= '0;
            pix         <= '0;
            px_x        <= '0;
            px_y        <= '0;
            init_done_q <= 1'b0;
        end else begin
            if (frame_start) init_done_q <= 1'b1;
            case (state)
                POWER_WAIT: cnt <= cnt + 32'd1;
                INIT_FETCH: begin
                    init_idx <= init_idx + 4'd1;
                    // counter reload so the next fetch lands exactly DELAY_CYCLES later
                    if (init_entry[9]) cnt <= DLY - 32'd1;
                    else begin
                        spi_data <= init_entry[8:0];
                        phase    <= PH_INIT;
                    end
                end
                DELAY:      cnt <= cnt - 32'd1;
                HDR_FETCH: begin
                    spi_data <= hdr_word;
                    hdr_idx  <= hdr_idx + 4'd1;
                    phase    <= PH_HDR;
                end
                PX_WAIT:    if (px_valid) pix <= px_data;
                PX_HI: begin
                    spi_data <= {1'b1, pix[15:8]};
                    phase    <= PH_HI;
                end
                PX_LO: begin
                    spi_data <= {1'b1, pix[7:0]};
                    phase    <= PH_LO;
                end
                WAIT_DONE: begin
                    if (spi_idle && phase == PH_HDR && hdr_idx == HDR_END) hdr_idx <= '0;
                    if (spi_idle && phase == PH_LO) begin
                        if (px_x == X_LAST) begin
                            px_x <= '0;
                            px_y <= (px_y == Y_LAST) ? 9'd0 : px_y + 9'd1;
                        end else begin
                            px_x <= px_x + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ili9341_frame_sequencer.sv
// Word-stream scoreboard for the frame sequencer: small 4x3 panel plus a default-geometry instance for the header.
module tb_ili9341_frame_sequencer;
    localparam int W = 4, H = 3, D = 10, BUSY = 20;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic        spi_idle = 1'b1, px_valid = 1'b1;
    logic [8:0]  spi_data;
    logic        spi_valid, px_ready, init_done, frame_start;
    logic [15:0] px_data;
    logic [7:0]  px_x;
    logic [8:0]  px_y;
    assign px_data = {px_y[7:0], px_x} + 16'h1234;

    ili9341_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .DELAY_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .spi_idle(spi_idle), .spi_data(spi_data), .spi_valid(spi_valid),
        .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
        .init_done(init_done), .frame_start(frame_start));

    logic        idle_b = 1'b1;
    logic [8:0]  data_b;
    logic        valid_b, ready_b, done_b, fs_b;
    logic [7:0]  x_b;
    logic [8:0]  y_b;
    ili9341_frame_sequencer #(.DELAY_CYCLES(D)) dut_big (
        .clk(clk), .rst(rst), .spi_idle(idle_b), .spi_data(data_b), .spi_valid(valid_b),
        .px_data(16'h0000), .px_valid(1'b0), .px_ready(ready_b), .px_x(x_b), .px_y(y_b),
        .init_done(done_b), .frame_start(fs_b));

    int errors = 0, checks = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct { logic [8:0] w; int x; int y; bit fs; bit done; bit lo; } exp_t;
    exp_t q[$];

    function automatic void push(logic [8:0] w, int x, int y, bit fs, bit done, bit lo);
        exp_t e;
        e.w = w; e.x = x; e.y = y; e.fs = fs; e.done = done; e.lo = lo;
        q.push_back(e);
    endfunction

    function automatic void build_model();
        int p;
        q.delete();
        push(9'h001, -1, -1, 0, 0, 0); push(9'h011, -1, -1, 0, 0, 0);
        push(9'h03A, -1, -1, 0, 0, 0); push(9'h155, -1, -1, 0, 0, 0);
        push(9'h036, -1, -1, 0, 0, 0); push(9'h148, -1, -1, 0, 0, 0);
        push(9'h029, -1, -1, 0, 0, 0);
        for (int f = 0; f < 2; f++) begin
            push(9'h02A, -1, -1, 1, 1, 0);
            push(9'h100, -1, -1, 0, 1, 0); push(9'h100, -1, -1, 0, 1, 0);
            push(9'(9'h100 | ((W - 1) >> 8)), -1, -1, 0, 1, 0);
            push(9'(9'h100 | ((W - 1) & 255)), -1, -1, 0, 1, 0);
            push(9'h02B, -1, -1, 0, 1, 0);
            push(9'h100, -1, -1, 0, 1, 0); push(9'h100, -1, -1, 0, 1, 0);
            push(9'(9'h100 | ((H - 1) >> 8)), -1, -1, 0, 1, 0);
            push(9'(9'h100 | ((H - 1) & 255)), -1, -1, 0, 1, 0);
            push(9'h02C, -1, -1, 0, 1, 0);
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    p = (y * 256 + x + 'h1234) & 'hFFFF;
                    push(9'(9'h100 | (p >> 8)), x, y, 0, 1, 0);
                    push(9'(9'h100 | (p & 255)), x, y, 0, 1, 1);
                end
        end
    endfunction

    // SPI master models: take the word, go busy, come back idle
    initial begin
        int busy = 0;
        logic v;
        forever begin
            @(negedge clk); v = spi_valid;
            @(posedge clk); #1;
            if (rst) begin spi_idle = 1'b1; busy = 0; end
            else if (busy > 0) begin busy--; if (busy == 0) spi_idle = 1'b1; end
            else if (v) begin spi_idle = 1'b0; busy = BUSY; end
        end
    end

    logic [8:0] cap_b [18];
    int nb = 0;
    initial begin
        int busy = 0;
        logic v;
        forever begin
            @(negedge clk); v = valid_b;
            if (v && nb < 18) begin cap_b[nb] = data_b; nb++; end
            @(posedge clk); #1;
            if (rst) begin idle_b = 1'b1; busy = 0; end
            else if (busy > 0) begin busy--; if (busy == 0) idle_b = 1'b1; end
            else if (v) begin idle_b = 1'b0; busy = 3; end
        end
    end

    int frames_seen = 0, pix_words = 0, nready = 0, nvalid = 0, rel = 0, t_rise = 0;
    bit prev_valid = 0, prev_idle = 1, first_seen = 0, wrap_pend = 0;

    // Compare process: scoreboard + handshake rules, every cycle out of reset
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                frames_seen = 0; pix_words = 0; nready = 0; nvalid = 0; rel = 0;
                prev_valid = 0; prev_idle = 1; first_seen = 0; wrap_pend = 0;
            end else begin
                rel++;
                if (spi_valid) chk("valid_while_busy", {31'd0, spi_idle}, 1);
                if (spi_valid) chk("valid_back_to_back", {31'd0, prev_valid}, 0);
                if (prev_idle && !spi_idle) begin
                    chk("valids_per_busy", nvalid, 1);
                    nvalid = 0;
                end
                if (!prev_idle && spi_idle) t_rise = rel;
                if (px_ready) nready++;
                if (!spi_valid) chk("frame_start_idle", {31'd0, frame_start}, 0);
                if (spi_valid) begin
                    nvalid++;
                    if (!first_seen) begin
                        chk("first_latency_ok", {31'd0, rel >= D}, 1);
                        chk("first_word", spi_data, 9'h001);
                        first_seen = 1;
                    end
                    if (spi_data == 9'h011) chk("delay_gap_ok", {31'd0, (rel - t_rise) >= D}, 1);
                    if (wrap_pend) begin chk("wrap_caset", spi_data, 9'h02A); wrap_pend = 0; end
                    if (frame_start) begin
                        if (frames_seen >= 1) chk("px_ready_per_frame", nready, W * H);
                        frames_seen++; nready = 0; pix_words = 0;
                    end
                    if (q.size() == 0) chk("scoreboard_underrun", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("word", spi_data, e.w);
                        chk("frame_start", {31'd0, frame_start}, {31'd0, e.fs});
                        chk("init_done", {31'd0, init_done}, {31'd0, e.done});
                        if (e.x >= 0) begin
                            chk("px_x", px_x, e.x);
                            chk("px_y", px_y, e.y);
                            pix_words++;
                            if (e.lo && e.x == W - 1 && e.y == H - 1) wrap_pend = 1;
                        end
                    end
                end
                prev_valid = spi_valid;
                prev_idle  = spi_idle;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    logic [8:0] big_exp [18] = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h029, 9'h02A, 9'h100,
                                 9'h100, 9'h100, 9'h1EF, 9'h02B, 9'h100, 9'h100, 9'h101, 9'h13F, 9'h02C};

    initial begin
        logic [7:0] x0;
        logic [8:0] y0;
        build_model();
        chk("model_col_end", q[11].w, 9'h103);
        chk("model_row_end", q[16].w, 9'h102);
        chk("model_px0_hi", q[18].w, 9'h112);
        chk("model_px0_lo", q[19].w, 9'h134);
        chk("model_last_lo", q[41].w, 9'h137);
        #1;
        chk("rst_spi_valid", {31'd0, spi_valid}, 0);
        chk("rst_spi_data", spi_data, 0);
        chk("rst_px_xy", {px_y, px_x}, 0);
        chk("rst_flags", {px_ready, init_done, frame_start}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20000 && !(frames_seen == 1 && pix_words >= 12); i++) @(posedge clk);
        chk("reach_stall", {31'd0, frames_seen == 1 && pix_words >= 12}, 1);
        @(posedge clk); #1 px_valid = 1'b0;
        repeat (30) @(posedge clk);
        #2 x0 = px_x; y0 = px_y;
        chk("stall_x", x0, 2);
        chk("stall_y", y0, 1);
        repeat (50) begin
            @(negedge clk);
            chk("stall_no_valid", {spi_valid, px_ready}, 0);
            chk("stall_xy", {px_y, px_x}, {y0, x0});
        end
        @(posedge clk); #1 px_valid = 1'b1;

        for (int i = 0; i < 20000 && !(frames_seen == 2 && pix_words >= 3); i++) @(posedge clk);
        chk("reach_reset", {31'd0, frames_seen == 2 && pix_words >= 3}, 1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_spi_valid", {31'd0, spi_valid}, 0);
        chk("arst_spi_data", spi_data, 0);
        chk("arst_px_xy", {px_y, px_x}, 0);
        chk("arst_flags", {px_ready, init_done, frame_start}, 0);
        repeat (3) @(negedge clk);
        build_model();
        rst = 1'b0;

        for (int i = 0; i < 20000 && frames_seen < 2; i++) @(posedge clk);
        chk("restart_two_frames", frames_seen, 2);
        chk("big_captured", nb, 18);
        for (int i = 0; i < 18; i++) chk($sformatf("big_hdr_%0d", i), cap_b[i], big_exp[i]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ili9341_frame_sequencer.md
Name: ili9341_frame_sequencer

Overview:
- Upstream command/pixel source for the 9-bit SPI master driving the ILI9341 panel.
- After reset, it waits out the power-on delay and plays a fixed initialisation sequence, including timed delays.
- It then streams full frames: CASET, PASET and RAMWR, followed by RGB565 pixels split into two bytes each.
- Words are handed to the SPI master one at a time using its available/idle handshake.

Parameters:
- WIDTH, 240: panel columns.
- HEIGHT, 320: panel rows.
- DELAY_CYCLES, 3000000: clk cycles per timed delay (120 ms at 25 MHz). Benches override it with a small value.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- spi_idle  input  1  SPI master idle flag
- spi_data  output  9  word to SPI master; bit8 = D/C (0 command, 1 data), bits7:0 = byte
- spi_valid  output  1  one-cycle strobe; spi_data is valid in the same cycle
- px_data  input  16  RGB565 pixel for the current px_x/px_y
- px_valid  input  1  px_data is valid
- px_ready  output  1  one-cycle pulse; pixel consumed
- px_x  output  8  current column, 0..WIDTH-1
- px_y  output  9  current row, 0..HEIGHT-1
- init_done  output  1  high from the first CASET onward
- frame_start  output  1  one-cycle pulse when a frame's CASET is issued

Behaviour:
- Reset values: spi_data=0, spi_valid=0, px_ready=0, px_x=0, px_y=0, init_done=0, frame_start=0. State=POWER_WAIT, delay counter cleared.
- Reset mid-operation aborts everything immediately. The sequence restarts from POWER_WAIT.
- States: POWER_WAIT, INIT_FETCH, DELAY, SEND, WAIT_BUSY, WAIT_DONE, HDR_FETCH, PX_WAIT, PX_HI, PX_LO.
- POWER_WAIT: count DELAY_CYCLES, then go to INIT_FETCH.
- Init table, in order:
  - 0x001 (SWRESET), delay
  - 0x011 (SLPOUT), delay
  - 0x03A, 0x155 (16 bpp)
  - 0x036, 0x148 (MADCTL)
  - 0x029 (DISPON)
- A delay entry loads the counter. The next fetch occurs exactly DELAY_CYCLES cycles later.
- Frame header, data bytes taken as 16-bit big-endian:
  - 0x02A, 0x100, 0x100, 0x1(hi WIDTH-1), 0x1(lo WIDTH-1)
  - 0x02B, 0x100, 0x100, 0x1(hi HEIGHT-1), 0x1(lo HEIGHT-1)
  - 0x02C
- Defaults give 0x100, 0x1EF for columns and 0x101, 0x13F for rows.
- SPI handshake:
  - SEND may assert spi_valid only when spi_idle=1.
  - Then WAIT_BUSY until spi_idle=0, then WAIT_DONE until spi_idle=1.
  - spi_valid is never asserted twice for the same word. There is never more than one word outstanding.
- Pixel phase:
  - PX_WAIT holds until px_valid=1.
  - px_data is then latched and px_ready pulses for one cycle.
  - Send {1'b1, px_data[15:8]}, then {1'b1, px_data[7:0]}.
- Pixel advance:
  - After the low byte is accepted, px_x increments.
  - px_x wraps to 0 at WIDTH-1, and px_y increments.
  - At the last pixel (WIDTH-1, HEIGHT-1), both wrap to 0 and the sequencer returns to the frame header (continuous refresh).
- frame_start and init_done change in the cycle spi_valid carries 0x02A.
- px_valid low for any number of cycles only stalls the sequencer. px_x/px_y are held stable while stalled.
- spi_idle already 0 on entering SEND: hold in SEND with spi_valid=0.
- Throughput: at most one word per SPI transfer, plus 3 cycles of handshake overhead.

Test Plan:
- Reset, DELAY_CYCLES=10, SPI model with a 20-cycle busy time:
  - First spi_valid occurs no earlier than cycle 10 after reset release, carrying 0x001.
  - Next spi_valid comes at least 10 cycles after idle returns.
- Full init capture: the word stream is exactly 0x001, 0x011, 0x03A, 0x155, 0x036, 0x148, 0x029. Then 0x02A with frame_start=1 and init_done=1, then 0x100, 0x100, 0x100, 0x1EF, 0x02B, 0x100, 0x100, 0x101, 0x13F, 0x02C.
- WIDTH=4, HEIGHT=3, px_data={px_y,px_x}-derived pattern:
  - 24 data words appear in order, high byte first.
  - px_ready pulses 12 times.
  - After (3,2), the next word is 0x02A.
- Hold px_valid=0 for 50 cycles mid-frame: no spi_valid occurs, and px_x/px_y stay constant. Resume: the stream continues with no lost or duplicated bytes.
- Assert rst during a pixel high-byte transfer:
  - Outputs return to their reset values asynchronously.
  - After release, the stream restarts with the POWER_WAIT delay and then 0x001.
- Handshake checker over the whole run:
  - spi_valid is never high while spi_idle=0.
  - spi_valid is never high on consecutive cycles.
  - There is exactly one spi_valid per idle low period.
